// File: rtl/logic_reset_sequencer_if.sv
// logic_reset_sequencer_if
//   Bundles the sequenced reset outputs of logic_reset_sequencer and, when
//   LOGIC_RESET_SEQUENCER_SW_RESET_EN is defined, the software reset handshake.
//   Ports carried:
//     reset_n       [OUTPUTS]  sequenced active-low resets, bit 0 released first
//     ready                    high once every reset_n bit is released
//     sw_reset_req             software reset request, level (macro only)
//     sw_reset_ack             software reset acknowledge, level (macro only)
//   Modports:
//     master  the sequencer side (drives resets, ready, ack)
//     slave   the consumer side (drives the software request)
interface logic_reset_sequencer_if #(
  parameter int OUTPUTS = 4
);

  logic [OUTPUTS-1:0] reset_n;
  logic               ready;

`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
  logic               sw_reset_req;
  logic               sw_reset_ack;

  modport master (
    output reset_n,
    output ready,
    output sw_reset_ack,
    input  sw_reset_req
  );

  modport slave (
    input  reset_n,
    input  ready,
    input  sw_reset_ack,
    output sw_reset_req
  );
`else
  modport master (
    output reset_n,
    output ready
  );

  modport slave (
    input  reset_n,
    input  ready
  );
`endif

endinterface

// File: rtl/logic_reset_sequencer.sv
// logic_reset_sequencer
//   Takes the synchronized active-low system reset and releases OUTPUTS
//   downstream reset domains one after another: every domain is held for HOLD
//   cycles after areset_n de-asserts, then bit 0 is released, and each further
//   bit follows STEP cycles after the previous one. ready rises together with
//   the last bit. All outputs come straight from flops.
//   Optional feature macro: LOGIC_RESET_SEQUENCER_SW_RESET_EN adds a software
//   reset request/acknowledge pair that pulls every output low for at least
//   SW_HOLD cycles and then re-runs the whole release sequence.
//   Ports:
//     aclk      clock
//     areset_n  async active-low reset, de-assertion synchronous to aclk
//     bus       logic_reset_sequencer_if.master (reset_n, ready,
//               sw_reset_req, sw_reset_ack)
module logic_reset_sequencer #(
  parameter int OUTPUTS = 4,
  parameter int HOLD    = 16,
  parameter int STEP    = 8,
  parameter int SW_HOLD = 4
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  logic_reset_sequencer_if.master   bus
);

  localparam int MAX_HS  = (HOLD > STEP) ? HOLD : STEP;
  localparam int MAX_ALL = (MAX_HS > SW_HOLD) ? MAX_HS : SW_HOLD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);
  localparam int IDX_W   = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP - 1);
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_HOLD - 1);
`endif
  // Index value of the second-to-last bit: releasing the bit after it ends
  // the sequence. Clamped for the single-output case, where RELEASE is never
  // entered.
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'((OUTPUTS > 1) ? OUTPUTS - 2 : 0);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
    , ST_SW_ASSERT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d, count_inc;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [OUTPUTS-1:0] rst_q, rst_d, release_mask;
  logic               ready_q, ready_d;
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
  logic               ack_q, ack_d;
`endif

  // Counter never wraps; it parks at all-ones if it ever gets there.
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

  // One-hot mask for the bit that follows the most recently released one.
  always_comb begin
    release_mask = '0;
    for (int k = 0; k < OUTPUTS; k++) begin
      if (k == int'(index_q) + 1) begin
        release_mask[k] = 1'b1;
      end
    end
  end

  // State, counter, index and output registers. areset_n forces everything
  // back to the start of the hold phase at any moment.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_HOLD;
      count_q <= '0;
      index_q <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
      ack_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
      ack_q   <= ack_d;
`endif
    end
  end

  // Next-state logic. Outputs only ever change by setting bits in rst_d, so
  // reset_n grows as a thermometer from bit 0 until a reset of some kind
  // clears it completely.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    rst_d   = rst_q;
    ready_d = ready_q;
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
    ack_d   = ack_q;
`endif

    case (state_q)
      ST_HOLD: begin
        if (count_q == HOLD_LAST) begin
          rst_d[0] = 1'b1;
          count_d  = '0;
          if (OUTPUTS == 1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          count_d = count_inc;
        end
      end

      ST_RELEASE: begin
        if (count_q == STEP_LAST) begin
          rst_d   = rst_q | release_mask;
          index_d = index_q + 1'b1;
          count_d = '0;
          if (index_q == PENULT_IDX) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          count_d = count_inc;
        end
      end

      ST_RUN: begin
        rst_d   = '1;
        ready_d = 1'b1;
      end

`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
      // Ack latches once the minimum low time is met and holds until the
      // request goes away; a request that already dropped still gets its
      // one-cycle ack before the sequence restarts.
      ST_SW_ASSERT: begin
        if (ack_q && !bus.sw_reset_req) begin
          ack_d   = 1'b0;
          count_d = '0;
          state_d = ST_HOLD;
        end else if (count_q == SW_LAST) begin
          ack_d = 1'b1;
        end else begin
          count_d = count_inc;
        end
      end
`endif

      default: begin
        state_d = ST_HOLD;
        count_d = '0;
        index_d = '0;
        rst_d   = '0;
        ready_d = 1'b0;
      end
    endcase

`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
    // A request outranks any release due on the same edge. Outside
    // SW_ASSERT ack is always low, so a fresh request is only seen after the
    // previous acknowledge has been withdrawn.
    if ((state_q != ST_SW_ASSERT) && bus.sw_reset_req) begin
      state_d = ST_SW_ASSERT;
      count_d = '0;
      index_d = '0;
      rst_d   = '0;
      ready_d = 1'b0;
      ack_d   = 1'b0;
    end
`endif
  end

  assign bus.reset_n = rst_q;
  assign bus.ready   = ready_q;
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
  assign bus.sw_reset_ack = ack_q;
`endif

endmodule

// File: tb/tb_logic_reset_sequencer.sv
// tb_logic_reset_sequencer
//   Self-checking bench for logic_reset_sequencer. Drives a 4-output instance
//   (HOLD=16, STEP=8, SW_HOLD=4) and a 1-output instance (HOLD=1, STEP=1)
//   from a shared clock and system reset. Software reset stimulus is only
//   applied when LOGIC_RESET_SEQUENCER_SW_RESET_EN is defined.
module tb_logic_reset_sequencer;

  localparam int OUTPUTS = 4;
  localparam int HOLD    = 16;
  localparam int STEP    = 8;
  localparam int SW_HOLD = 4;
  localparam int NV      = 11;

  logic aclk = 1'b0;
  logic areset_n;
  int   checks = 0;
  int   errors = 0;

  logic_reset_sequencer_if #(.OUTPUTS(OUTPUTS)) bus0 ();
  logic_reset_sequencer_if #(.OUTPUTS(1))       bus1 ();

`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
  logic req = 1'b0;
  assign bus0.sw_reset_req = req;
  assign bus1.sw_reset_req = 1'b0;
`endif

  logic_reset_sequencer #(
    .OUTPUTS(OUTPUTS), .HOLD(HOLD), .STEP(STEP), .SW_HOLD(SW_HOLD)
  ) dut0 (
    .aclk(aclk), .areset_n(areset_n), .bus(bus0)
  );

  logic_reset_sequencer #(
    .OUTPUTS(1), .HOLD(1), .STEP(1), .SW_HOLD(1)
  ) dut1 (
    .aclk(aclk), .areset_n(areset_n), .bus(bus1)
  );

  always #5 aclk = ~aclk;

  // Expected timeline after a system reset release, edge numbers counted
  // from the first rising edge after de-assertion.
  typedef struct {
    int         edge_no;
    logic [3:0] rst_exp;
    logic       rdy_exp;
    logic       rst1_exp;
    logic       rdy1_exp;
  } vec_t;

  vec_t tbl [NV];

  // Reference model: time since the sequence (re)started, plus software
  // reset phase bookkeeping.
  int t0, t1, sw_e;
  bit sw_mode, ack_exp;

  function automatic logic [31:0] thermo(int t, int n, int hold, int step);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      if (t >= hold + k * step) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] req_val);
    checks++;
    if (act !== req_val) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req_val);
    end
  endtask

  task automatic model_reset();
    t0 = 0;
    t1 = 0;
    sw_e = 0;
    sw_mode = 1'b0;
    ack_exp = 1'b0;
  endtask

  task automatic model_edge();
    if (!areset_n) begin
      model_reset();
    end else begin
      if (t1 < 1000000) t1++;
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
      if (sw_mode) begin
        if (ack_exp && !req) begin
          sw_mode = 1'b0;
          ack_exp = 1'b0;
          t0 = 0;
        end else begin
          sw_e++;
          ack_exp = (sw_e >= SW_HOLD);
        end
      end else if (req) begin
        sw_mode = 1'b1;
        sw_e = 0;
        ack_exp = 1'b0;
      end else if (t0 < 1000000) begin
        t0++;
      end
`else
      if (t0 < 1000000) t0++;
`endif
    end
  endtask

  task automatic compare_model();
    logic [31:0] e0;
    e0 = sw_mode ? 32'd0 : thermo(t0, OUTPUTS, HOLD, STEP);
    check_output("model_reset_n", 32'(bus0.reset_n), e0);
    check_output("model_ready", 32'(bus0.ready),
                 32'(!sw_mode && (t0 >= HOLD + (OUTPUTS - 1) * STEP)));
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
    check_output("model_ack", 32'(bus0.sw_reset_ack), 32'(ack_exp));
`endif
    check_output("model1_reset_n", 32'(bus1.reset_n), thermo(t1, 1, 1, 1));
    check_output("model1_ready", 32'(bus1.ready), 32'(t1 >= 1));
  endtask

  // One clock: model follows the rising edge, outputs checked on the falling
  // edge, and the caller drives new inputs right after.
  task automatic tick();
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
    compare_model();
  endtask

  task automatic apply_async_reset();
    areset_n = 1'b0;
    model_reset();
    #1;
    check_output("async_reset_n", 32'(bus0.reset_n), 32'd0);
    check_output("async_ready", 32'(bus0.ready), 32'd0);
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
    check_output("async_ack", 32'(bus0.sw_reset_ack), 32'd0);
`endif
    check_output("async1_reset_n", 32'(bus1.reset_n), 32'd0);
    check_output("async1_ready", 32'(bus1.ready), 32'd0);
  endtask

  task automatic reset_and_release(int cycles);
    apply_async_reset();
    repeat (cycles) tick();
    areset_n = 1'b1;
  endtask

  task automatic run_table();
    for (int n = 1; n <= 60; n++) begin
      tick();
      for (int i = 0; i < NV; i++) begin
        if (tbl[i].edge_no == n) begin
          check_output($sformatf("tbl_reset_n_e%0d", n), 32'(bus0.reset_n), 32'(tbl[i].rst_exp));
          check_output($sformatf("tbl_ready_e%0d", n), 32'(bus0.ready), 32'(tbl[i].rdy_exp));
          check_output($sformatf("tbl1_reset_n_e%0d", n), 32'(bus1.reset_n), 32'(tbl[i].rst1_exp));
          check_output($sformatf("tbl1_ready_e%0d", n), 32'(bus1.ready), 32'(tbl[i].rdy1_exp));
        end
      end
    end
  endtask

  // Random system resets and (when present) software requests, checked
  // every cycle against the model.
  task automatic apply_stimulus(int cycles);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 999) < 8) begin
        apply_async_reset();
        repeat ($urandom_range(0, 2)) tick();
        areset_n = 1'b1;
      end
`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
      if (req) begin
        if ($urandom_range(0, 99) < 15) req = 1'b0;
      end else if ($urandom_range(0, 99) < 3) begin
        req = 1'b1;
      end
`endif
      tick();
    end
  endtask

  initial begin
    tbl[0]  = '{1,  4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{15, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{16, 4'b0001, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{23, 4'b0001, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{24, 4'b0011, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{31, 4'b0011, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{32, 4'b0111, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{39, 4'b0111, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{40, 4'b1111, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{41, 4'b1111, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{60, 4'b1111, 1'b1, 1'b1, 1'b1};

    areset_n = 1'b1;
    model_reset();
    #2;

    // Power-on reset, then the nominal release timeline.
    reset_and_release(3);
    run_table();

    // System reset in the middle of the sequence, then a clean re-run.
    reset_and_release(2);
    repeat (28) tick();
    check_output("t2_edge28_reset_n", 32'(bus0.reset_n), 32'b0011);
    reset_and_release(3);
    run_table();

`ifdef LOGIC_RESET_SEQUENCER_SW_RESET_EN
    // Held software request from RUN.
    req = 1'b1;
    tick();
    check_output("t3_reset_n_low", 32'(bus0.reset_n), 32'd0);
    check_output("t3_ready_low", 32'(bus0.ready), 32'd0);
    repeat (3) begin
      tick();
      check_output("t3_ack_early", 32'(bus0.sw_reset_ack), 32'd0);
    end
    tick();
    check_output("t3_ack_rise", 32'(bus0.sw_reset_ack), 32'd1);
    tick();
    check_output("t3_ack_hold", 32'(bus0.sw_reset_ack), 32'd1);
    req = 1'b0;
    tick();
    check_output("t3_ack_fall", 32'(bus0.sw_reset_ack), 32'd0);
    repeat (15) begin
      tick();
      check_output("t3_bit0_low", 32'(bus0.reset_n[0]), 32'd0);
    end
    tick();
    check_output("t3_bit0_rise", 32'(bus0.reset_n[0]), 32'd1);

    // One-cycle request pulse during RELEASE.
    reset_and_release(2);
    repeat (20) tick();
    check_output("t4_edge20_reset_n", 32'(bus0.reset_n), 32'b0001);
    req = 1'b1;
    tick();
    check_output("t4_edge21_reset_n", 32'(bus0.reset_n), 32'd0);
    req = 1'b0;
    repeat (3) begin
      tick();
      check_output("t4_ack_early", 32'(bus0.sw_reset_ack), 32'd0);
    end
    tick();
    check_output("t4_ack_edge25", 32'(bus0.sw_reset_ack), 32'd1);
    tick();
    check_output("t4_ack_edge26", 32'(bus0.sw_reset_ack), 32'd0);
    repeat (15) tick();
    check_output("t4_bit0_low", 32'(bus0.reset_n[0]), 32'd0);
    tick();
    check_output("t4_bit0_rise", 32'(bus0.reset_n[0]), 32'd1);

    // Request sampled on the very edge that would release bit 1.
    reset_and_release(2);
    repeat (23) tick();
    req = 1'b1;
    tick();
    check_output("coincident_reset_n", 32'(bus0.reset_n), 32'd0);
    repeat (4) tick();
    check_output("coincident_ack", 32'(bus0.sw_reset_ack), 32'd1);
    req = 1'b0;
    tick();
    check_output("coincident_ack_fall", 32'(bus0.sw_reset_ack), 32'd0);
`endif

    apply_stimulus(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
